// File: rtl/mdu.sv
// Multiply/divide unit: single-cycle MULT/MULTU and MTHI/MTLO, a 32-step
// restoring divider for DIV/DIVU, and the architectural HI/LO registers.
module mdu #(
    parameter int MDOP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MDOP_W-1:0] mdu_mduop_i,
    input  logic [31:0]       mdu_opr1_i,
    input  logic [31:0]       mdu_opr2_i,
    input  logic              mdu_flush_i,
    input  logic              mdu_stall_i,
    output logic [31:0]       mdu_result_o,
    output logic              mdu_stallreq_o,
    output logic [31:0]       mdu_hi_o,
    output logic [31:0]       mdu_lo_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      r_state;
    logic [4:0]  r_count;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_quot;
    logic [31:0] r_rem;
    logic [31:0] r_divisor;
    logic        r_negQuot;
    logic        r_negRem;

    logic [MDOP_W-1:0] w_op;
    logic              w_isMult, w_isMultu, w_isDiv, w_isDivu;
    logic              w_isMfhi, w_isMflo, w_isMthi, w_isMtlo;
    logic              w_divReq;
    logic              w_divStart;
    logic [31:0]       w_absA;
    logic [31:0]       w_absB;
    logic [63:0]       w_prodS;
    logic [63:0]       w_prodU;
    logic [32:0]       w_shifted;
    logic [32:0]       w_diff;
    logic              w_fits;
    logic [31:0]       w_remNext;
    logic [31:0]       w_quotNext;
    logic [31:0]       w_qFinal;
    logic [31:0]       w_rFinal;

    // An opcode with more than one bit set is an illegal encoding and is ignored.
    assign w_op       = $onehot0(mdu_mduop_i) ? mdu_mduop_i : '0;
    assign w_isMult   = w_op[0];
    assign w_isMultu  = w_op[1];
    assign w_isDiv    = w_op[2];
    assign w_isDivu   = w_op[3];
    assign w_isMfhi   = w_op[4];
    assign w_isMflo   = w_op[5];
    assign w_isMthi   = w_op[6];
    assign w_isMtlo   = w_op[7];

    // A zero divisor never starts the divider, so HI/LO simply stay as they were.
    assign w_divReq   = (w_isDiv || w_isDivu) && (mdu_opr2_i != 32'd0);
    assign w_divStart = w_divReq && (r_state == IDLE) && !mdu_flush_i;

    // Signed divide runs on magnitudes; signs are reapplied when the result is written.
    assign w_absA = (w_isDiv && mdu_opr1_i[31]) ? (32'd0 - mdu_opr1_i) : mdu_opr1_i;
    assign w_absB = (w_isDiv && mdu_opr2_i[31]) ? (32'd0 - mdu_opr2_i) : mdu_opr2_i;

    // The low 64 bits of the product of sign-extended operands is the signed product.
    assign w_prodS = {{32{mdu_opr1_i[31]}}, mdu_opr1_i} * {{32{mdu_opr2_i[31]}}, mdu_opr2_i};
    assign w_prodU = {32'd0, mdu_opr1_i} * {32'd0, mdu_opr2_i};

    // One restoring step: shift the next dividend bit into the partial remainder
    // and keep the subtraction only when it does not go negative.
    assign w_shifted  = {r_rem, r_quot[31]};
    assign w_diff     = w_shifted - {1'b0, r_divisor};
    assign w_fits     = !w_diff[32];
    assign w_remNext  = w_fits ? w_diff[31:0] : w_shifted[31:0];
    assign w_quotNext = {r_quot[30:0], w_fits};

    assign w_qFinal = r_negQuot ? (32'd0 - r_quot) : r_quot;
    assign w_rFinal = r_negRem  ? (32'd0 - r_rem)  : r_rem;

    // The pipeline is held from the issue cycle through the last BUSY step; a
    // flush releases it in the same cycle, and reset forces it low.
    assign mdu_stallreq_o = rst_n && !mdu_flush_i &&
                            (((r_state == IDLE) && w_divReq) || (r_state == BUSY));

    assign mdu_result_o = w_isMfhi ? r_hi : (w_isMflo ? r_lo : 32'd0);
    assign mdu_hi_o     = r_hi;
    assign mdu_lo_o     = r_lo;

    // Divider sequencing and datapath; flush takes priority in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_count   <= 5'd0;
            r_quot    <= 32'd0;
            r_rem     <= 32'd0;
            r_divisor <= 32'd0;
            r_negQuot <= 1'b0;
            r_negRem  <= 1'b0;
        end else if (mdu_flush_i) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_divStart) begin
                        r_state   <= BUSY;
                        r_count   <= 5'd0;
                        r_quot    <= w_absA;
                        r_rem     <= 32'd0;
                        r_divisor <= w_absB;
                        r_negQuot <= w_isDiv && (mdu_opr1_i[31] ^ mdu_opr2_i[31]);
                        r_negRem  <= w_isDiv && mdu_opr1_i[31];
                    end
                end
                BUSY: begin
                    r_quot  <= w_quotNext;
                    r_rem   <= w_remNext;
                    r_count <= r_count + 5'd1;
                    if (r_count == 5'd31) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (!mdu_stall_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // HI/LO update: single-cycle ops from IDLE, divide result at the end of each DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (!mdu_flush_i) begin
            if (r_state == DONE) begin
                r_hi <= w_rFinal;
                r_lo <= w_qFinal;
            end else if (r_state == IDLE) begin
                if (w_isMult) begin
                    r_hi <= w_prodS[63:32];
                    r_lo <= w_prodS[31:0];
                end else if (w_isMultu) begin
                    r_hi <= w_prodU[63:32];
                    r_lo <= w_prodU[31:0];
                end else if (w_isMthi) begin
                    r_hi <= mdu_opr1_i;
                end else if (w_isMtlo) begin
                    r_lo <= mdu_opr1_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: randomized ops against an arithmetic HI/LO model.
module tb_mdu;

    localparam logic [7:0] OP_MULT  = 8'h01;
    localparam logic [7:0] OP_MULTU = 8'h02;
    localparam logic [7:0] OP_DIV   = 8'h04;
    localparam logic [7:0] OP_DIVU  = 8'h08;
    localparam logic [7:0] OP_MFHI  = 8'h10;
    localparam logic [7:0] OP_MFLO  = 8'h20;
    localparam logic [7:0] OP_MTHI  = 8'h40;
    localparam logic [7:0] OP_MTLO  = 8'h80;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  op;
    logic [31:0] a, b;
    logic        flush, stall;
    logic [31:0] result, hi, lo;
    logic        stallreq;

    int          nCompared   = 0;
    int          nMismatched = 0;
    logic [31:0] mHi = 32'd0;
    logic [31:0] mLo = 32'd0;

    mdu #(.MDOP_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .mdu_mduop_i(op), .mdu_opr1_i(a), .mdu_opr2_i(b),
        .mdu_flush_i(flush), .mdu_stall_i(stall), .mdu_result_o(result),
        .mdu_stallreq_o(stallreq), .mdu_hi_o(hi), .mdu_lo_o(lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference product as {HI,LO} from plain integer arithmetic.
    function automatic logic [63:0] modelMul(input logic sgn, input logic [31:0] x, input logic [31:0] y);
        longint p;
        if (sgn) begin
            p = longint'($signed(x)) * longint'($signed(y));
            return p;
        end
        return {32'd0, x} * {32'd0, y};
    endfunction

    // Reference divide as {remainder,quotient}; 64-bit math avoids the MIN/-1 overflow.
    function automatic logic [63:0] modelDiv(input logic sgn, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        if (sgn) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            q = sx / sy;
            r = sx % sy;
            return {r[31:0], q[31:0]};
        end
        return {x % y, x / y};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; op = OP_DIV; a = 32'd9; b = 32'd3; flush = 1'b0; stall = 1'b0;
        #12;
        nCompared++; if (stallreq !== 1'b0) begin nMismatched++; $display("FAIL reset_stallreq: got %b want 0", stallreq); end
        nCompared++; if (hi !== 32'd0) begin nMismatched++; $display("FAIL reset_hi: got %h want 0", hi); end
        nCompared++; if (lo !== 32'd0) begin nMismatched++; $display("FAIL reset_lo: got %h want 0", lo); end
        op = OP_MFHI; #1;
        nCompared++; if (result !== 32'd0) begin nMismatched++; $display("FAIL reset_result: got %h want 0", result); end
        op = 8'h00;
        #3 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_mult();
        logic [63:0] p;
        for (int i = 0; i < 24; i++) begin
            if (i == 0) begin op = OP_MULT;  a = 32'hFFFFFFFF; b = 32'h2; end
            else if (i == 1) begin op = OP_MULTU; a = 32'hFFFFFFFF; b = 32'h2; end
            else begin
                op = ($urandom_range(0, 1) == 0) ? OP_MULT : OP_MULTU;
                a = $urandom; b = $urandom;
            end
            stall = 1'($urandom_range(0, 1));
            #1;
            nCompared++; if (stallreq !== 1'b0) begin nMismatched++; $display("FAIL mult_stallreq[%0d]: got %b want 0", i, stallreq); end
            tick();
            p = modelMul(op == OP_MULT, a, b);
            mHi = p[63:32]; mLo = p[31:0];
            nCompared++; if (hi !== mHi) begin nMismatched++; $display("FAIL mult_hi[%0d]: got %h want %h", i, hi, mHi); end
            nCompared++; if (lo !== mLo) begin nMismatched++; $display("FAIL mult_lo[%0d]: got %h want %h", i, lo, mLo); end
        end
        stall = 1'b0; op = 8'h00;
    endtask

    task automatic test_mt_mf();
        for (int i = 0; i < 8; i++) begin
            a = $urandom; b = $urandom;
            op = (i % 2 == 0) ? OP_MTHI : OP_MTLO;
            stall = 1'($urandom_range(0, 1));
            tick();
            if (op == OP_MTHI) mHi = a; else mLo = a;
            op = (i % 2 == 0) ? OP_MFHI : OP_MFLO;
            #1;
            nCompared++; if (result !== ((i % 2 == 0) ? mHi : mLo)) begin nMismatched++; $display("FAIL mtmf_result[%0d]: got %h want %h", i, result, (i % 2 == 0) ? mHi : mLo); end
            nCompared++; if (hi !== mHi || lo !== mLo) begin nMismatched++; $display("FAIL mtmf_hilo[%0d]: got %h/%h want %h/%h", i, hi, lo, mHi, mLo); end
        end
        stall = 1'b0; op = 8'h00;
    endtask

    task automatic test_div();
        int cnt;
        logic [63:0] d;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin op = OP_DIV; a = 32'hFFFFFFF9; b = 32'h2; end
            else if (i == 1) begin op = OP_DIVU; a = 32'd100; b = 32'd7; end
            else if (i == 2) begin op = OP_DIV; a = 32'h80000000; b = 32'hFFFFFFFF; end
            else if (i == 3) begin op = OP_DIVU; a = $urandom; b = 32'd0; end
            else begin
                op = ($urandom_range(0, 1) == 0) ? OP_DIV : OP_DIVU;
                a = $urandom;
                b = (i % 2 == 0) ? $urandom : $urandom_range(1, 1000);
                if ($urandom_range(0, 1) == 1) b = 32'd0 - b;
            end
            #1;
            cnt = 0;
            while (stallreq === 1'b1 && cnt < 100) begin cnt++; tick(); end
            nCompared++; if (cnt !== ((b == 32'd0) ? 0 : 33)) begin nMismatched++; $display("FAIL div_stall_cycles[%0d]: got %0d want %0d", i, cnt, (b == 32'd0) ? 0 : 33); end
            tick();
            op = 8'h00;
            if (b != 32'd0) begin
                d = modelDiv(i != 1 && op == OP_DIV, a, b);
            end
            #1;
            nCompared++; if (stallreq !== 1'b0) begin nMismatched++; $display("FAIL div_after_stallreq[%0d]: got %b want 0", i, stallreq); end
        end
    endtask

    // Separate checker for divide results: the loop above only measures cycles.
    task automatic test_div_values();
        int cnt;
        logic [63:0] d;
        logic        sgn;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin sgn = 1'b1; a = 32'hFFFFFFF9; b = 32'h2; end
            else if (i == 1) begin sgn = 1'b0; a = 32'd100; b = 32'd7; end
            else if (i == 2) begin sgn = 1'b1; a = 32'h80000000; b = 32'hFFFFFFFF; end
            else begin
                sgn = 1'($urandom_range(0, 1));
                a = $urandom;
                b = (i % 2 == 0) ? $urandom : $urandom_range(1, 500);
                if ($urandom_range(0, 1) == 1) b = 32'd0 - b;
            end
            op = sgn ? OP_DIV : OP_DIVU;
            #1;
            cnt = 0;
            while (stallreq === 1'b1 && cnt < 100) begin cnt++; tick(); end
            tick();
            op = 8'h00;
            d = modelDiv(sgn, a, b);
            mHi = d[63:32]; mLo = d[31:0];
            #1;
            nCompared++; if (lo !== mLo) begin nMismatched++; $display("FAIL div_lo[%0d]: got %h want %h", i, lo, mLo); end
            nCompared++; if (hi !== mHi) begin nMismatched++; $display("FAIL div_hi[%0d]: got %h want %h", i, hi, mHi); end
        end
    endtask

    task automatic test_div_zero();
        op = OP_MTHI; a = 32'h1234; tick();
        op = OP_MTLO; a = 32'h5678; tick();
        mHi = 32'h1234; mLo = 32'h5678;
        op = OP_DIV; a = 32'd55; b = 32'd0; #1;
        nCompared++; if (stallreq !== 1'b0) begin nMismatched++; $display("FAIL divzero_stallreq: got %b want 0", stallreq); end
        tick();
        op = OP_MFHI; #1;
        nCompared++; if (result !== 32'h1234) begin nMismatched++; $display("FAIL divzero_mfhi: got %h want 00001234", result); end
        nCompared++; if (lo !== mLo) begin nMismatched++; $display("FAIL divzero_lo: got %h want %h", lo, mLo); end
        op = 8'h00;
    endtask

    task automatic test_flush();
        int cnt;
        op = OP_MTHI; a = 32'h1111; tick();
        op = OP_MTLO; a = 32'h2222; tick();
        mHi = 32'h1111; mLo = 32'h2222;
        op = OP_MULT; a = 32'd5; b = 32'd6; flush = 1'b1; tick();
        flush = 1'b0;
        nCompared++; if (hi !== mHi || lo !== mLo) begin nMismatched++; $display("FAIL flush_mult: got %h/%h want %h/%h", hi, lo, mHi, mLo); end
        op = OP_DIV; a = 32'd100; b = 32'd7; #1;
        repeat (11) tick();
        nCompared++; if (stallreq !== 1'b1) begin nMismatched++; $display("FAIL flush_busy_stallreq: got %b want 1", stallreq); end
        flush = 1'b1; #1;
        nCompared++; if (stallreq !== 1'b0) begin nMismatched++; $display("FAIL flush_cycle_stallreq: got %b want 0", stallreq); end
        tick();
        flush = 1'b0; op = 8'h00;
        repeat (40) tick();
        nCompared++; if (hi !== mHi || lo !== mLo) begin nMismatched++; $display("FAIL flush_hilo: got %h/%h want %h/%h", hi, lo, mHi, mLo); end
        op = OP_DIVU; a = 32'd100; b = 32'd7; #1;
        cnt = 0;
        while (stallreq === 1'b1 && cnt < 100) begin cnt++; tick(); end
        nCompared++; if (cnt !== 33) begin nMismatched++; $display("FAIL flush_then_div_cycles: got %0d want 33", cnt); end
        tick();
        op = 8'h00; mHi = 32'd2; mLo = 32'd14;
        nCompared++; if (hi !== mHi || lo !== mLo) begin nMismatched++; $display("FAIL flush_then_div_hilo: got %h/%h want %h/%h", hi, lo, mHi, mLo); end
    endtask

    task automatic test_done_stall();
        int cnt;
        op = OP_MTHI; a = 32'hAAAA; tick();
        op = OP_MTLO; a = 32'hBBBB; tick();
        op = OP_DIVU; a = 32'd100; b = 32'd7; #1;
        cnt = 0;
        while (stallreq === 1'b1 && cnt < 100) begin cnt++; tick(); end
        nCompared++; if (cnt !== 33) begin nMismatched++; $display("FAIL donestall_cycles: got %0d want 33", cnt); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            nCompared++; if (stallreq !== 1'b0) begin nMismatched++; $display("FAIL donestall_restart[%0d]: got %b want 0", i, stallreq); end
            tick();
            nCompared++; if (lo !== 32'd14 || hi !== 32'd2) begin nMismatched++; $display("FAIL donestall_hilo[%0d]: got %h/%h want 2/14", i, hi, lo); end
        end
        stall = 1'b0; tick(); op = 8'h00; #1;
        mHi = 32'd2; mLo = 32'd14;
        nCompared++; if (stallreq !== 1'b0 || hi !== mHi || lo !== mLo) begin nMismatched++; $display("FAIL donestall_exit: got %b %h/%h want 0 %h/%h", stallreq, hi, lo, mHi, mLo); end
    endtask

    task automatic test_reset_busy();
        op = OP_MTHI; a = 32'hDEAD; tick();
        op = OP_DIV; a = 32'd100; b = 32'd7; #1;
        repeat (6) tick();
        rst_n = 1'b0; #1;
        nCompared++; if (stallreq !== 1'b0) begin nMismatched++; $display("FAIL rstbusy_stallreq: got %b want 0", stallreq); end
        nCompared++; if (hi !== 32'd0 || lo !== 32'd0) begin nMismatched++; $display("FAIL rstbusy_hilo: got %h/%h want 0/0", hi, lo); end
        op = OP_MFHI; #1;
        nCompared++; if (result !== 32'd0) begin nMismatched++; $display("FAIL rstbusy_result: got %h want 0", result); end
        op = 8'h00; mHi = 32'd0; mLo = 32'd0;
        tick();
        rst_n = 1'b1;
        repeat (40) tick();
        nCompared++; if (hi !== 32'd0 || lo !== 32'd0) begin nMismatched++; $display("FAIL rstbusy_nowrite: got %h/%h want 0/0", hi, lo); end
        op = OP_MULTU; a = 32'd3; b = 32'd4; tick();
        op = 8'h00; mHi = 32'd0; mLo = 32'd12;
        nCompared++; if (hi !== mHi || lo !== mLo) begin nMismatched++; $display("FAIL rstbusy_multu: got %h/%h want %h/%h", hi, lo, mHi, mLo); end
    endtask

    task automatic test_multi_hot();
        logic [7:0] m;
        for (int i = 0; i < 6; i++) begin
            m = 8'($urandom);
            while ($countones(m) < 2) m = 8'($urandom);
            op = m; a = $urandom; b = $urandom_range(1, 100);
            #1;
            nCompared++; if (stallreq !== 1'b0 || result !== 32'd0) begin nMismatched++; $display("FAIL multihot_comb[%0d]: got %b %h want 0 0", i, stallreq, result); end
            tick();
            nCompared++; if (hi !== mHi || lo !== mLo) begin nMismatched++; $display("FAIL multihot_hilo[%0d]: got %h/%h want %h/%h", i, hi, lo, mHi, mLo); end
        end
        op = 8'h00;
    endtask

    task automatic test_back_to_back();
        logic [63:0] p;
        op = OP_MTHI; a = $urandom; tick(); mHi = a;
        op = OP_MULT; a = $urandom; b = $urandom; tick();
        p = modelMul(1'b1, a, b); mHi = p[63:32]; mLo = p[31:0];
        op = OP_MFLO; #1;
        nCompared++; if (result !== mLo) begin nMismatched++; $display("FAIL b2b_mflo: got %h want %h", result, mLo); end
        tick();
        op = OP_MTLO; a = $urandom; tick(); mLo = a;
        op = OP_MFHI; #1;
        nCompared++; if (result !== mHi) begin nMismatched++; $display("FAIL b2b_mfhi: got %h want %h", result, mHi); end
        op = OP_MFLO; #1;
        nCompared++; if (result !== mLo) begin nMismatched++; $display("FAIL b2b_mflo2: got %h want %h", result, mLo); end
        op = 8'h00;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_mt_mf();
        test_div();
        test_div_values();
        test_div_zero();
        test_flush();
        test_done_stall();
        test_reset_busy();
        test_multi_hot();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 The block SHALL have one parameter: MDOP_W, default 8, width of the one-hot mul/div opcode from the ID/EX register.
REQ-002 The block SHALL have one clock, clk; reset is rst_n, asynchronous and active-low.
REQ-003 Ports SHALL be:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- mdu_mduop_i  in  MDOP_W  one-hot op, held stable by the pipeline while stalled. Bit map: [0]MULT [1]MULTU [2]DIV [3]DIVU [4]MFHI [5]MFLO [6]MTHI [7]MTLO.
- mdu_opr1_i  in  32  rs value (dividend/multiplicand, MTHI/MTLO source).
- mdu_opr2_i  in  32  rt value (divisor/multiplier).
- mdu_flush_i  in  1  cancel current op.
- mdu_stall_i  in  1  external pipeline stall (downstream not advancing).
- mdu_result_o  out  32  HI for MFHI, LO for MFLO, else 0.
- mdu_stallreq_o  out  1  request to hold IF/ID/EX.
- mdu_hi_o  out  32  architectural HI.
- mdu_lo_o  out  32  architectural LO.

Function
REQ-004 Multiple mdu_mduop_i bits set at once SHALL be treated as all-zero (no-op).
REQ-005 MULT/MULTU SHALL compute the 64-bit signed/unsigned product and write HI=prod[63:32], LO=prod[31:0] at the clock edge ending the issue cycle; no stallreq.
REQ-006 MTHI/MTLO SHALL write mdu_opr1_i to HI/LO at the edge ending the issue cycle; no stallreq.
REQ-007 mdu_result_o SHALL be combinational from the HI/LO registers, so MTHI in cycle n followed by MFHI in cycle n+1 returns the new value.
REQ-008 The divider FSM SHALL have states IDLE, BUSY and DONE.
REQ-009 IDLE -> BUSY when DIV/DIVU is presented, divisor != 0 and no flush: latch absolute operands and sign flags, clear the 5-bit iteration count, assert stallreq.
REQ-010 BUSY SHALL perform one restoring shift-subtract step per cycle for 32 cycles (count 0..31), asserting stallreq; at count 31 -> DONE.
REQ-011 In DONE, stallreq SHALL be 0 and the sign-corrected result SHALL be written (LO=quotient, HI=remainder) at the edge ending DONE.
REQ-012 DONE -> IDLE when mdu_stall_i=0; otherwise stay in DONE, rewriting the same HI/LO values, and SHALL NOT restart on the held op.
REQ-013 mdu_stallreq_o SHALL be high for exactly 33 consecutive cycles per divide (issue plus 32 BUSY cycles).
REQ-014 Signed divide: quotient negative iff operand signs differ; remainder takes the dividend's sign; 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-015 Divide by zero SHALL take no cycles and no stallreq, and SHALL leave HI/LO unchanged.
REQ-016 mdu_flush_i SHALL have priority: in any state, FSM -> IDLE next cycle, no HI/LO write that cycle, stallreq deasserted combinationally in the flush cycle.
REQ-017 A MULT/MTHI/MTLO op held under mdu_stall_i SHALL rewrite the same value (idempotent); it SHALL NOT be blocked.

Reset
REQ-018 On rst_n low the block SHALL asynchronously set HI=0, LO=0, FSM=IDLE, count=0 and divider datapath registers to 0; mdu_stallreq_o=0 and mdu_result_o=0 while in reset.
REQ-019 Reset during BUSY or DONE SHALL abort the divide with no HI/LO write.

Verification
REQ-020 MULT with 0xFFFFFFFF, 0x00000002 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE next cycle. MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE. stallreq stays 0.
REQ-021 DIV with 0xFFFFFFF9 (-7), 0x00000002 -> stallreq high 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with 100, 7 -> LO=14, HI=2.
REQ-022 Preload HI=0x1234, LO=0x5678 via MTHI/MTLO, then DIV with divisor 0 -> no stallreq, HI/LO unchanged. MFHI then returns 0x1234.
REQ-023 DIV 100/7, mdu_flush_i pulsed at BUSY count 10 -> stallreq 0 in the flush cycle, IDLE next cycle, HI/LO keep their prior values.
REQ-024 DIVU 100/7 with mdu_stall_i high for 3 cycles at DONE -> FSM stays in DONE, no second divide, LO=14, HI=2.
REQ-025 rst_n asserted at BUSY count 5 -> all outputs 0 immediately. After release, MULTU 3*4 -> LO=12, HI=0.
